// File: rtl/st7789_spi_tx.sv
// ============================================================================
// Module   : st7789_spi_tx
// Brief    : AXI-Stream to SPI serializer for ST7789-class panels, with
//            TKEEP lane dropping, TLAST-framed chip select and a CS-high gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module st7789_spi_tx #(
    parameter int BYTES_PER_BEAT = 2,
    parameter int CLK_DIV        = 4,
    parameter int CPOL           = 1,
    parameter int CS_HOLD        = 2
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic [8*BYTES_PER_BEAT-1:0] S_AXIS_TDATA,
    input  logic [BYTES_PER_BEAT-1:0]   S_AXIS_TKEEP,
    input  logic                        S_AXIS_TUSER,
    input  logic                        S_AXIS_TVALID,
    input  logic                        S_AXIS_TLAST,
    output logic                        S_AXIS_TREADY,
    output logic                        LCD_CS,
    output logic                        LCD_DC,
    output logic                        LCD_SDA,
    output logic                        LCD_SCK,
    output logic                        BUSY,
    output logic                        FRAME_DONE
);

    localparam int c_w      = 8 * BYTES_PER_BEAT;
    localparam int c_bits_w = $clog2(c_w + 1);
    localparam int c_cnt_w  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int c_gap_w  = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLK_DIV / 2);
    localparam logic [c_cnt_w-1:0] c_cnt_pre  = c_cnt_w'(CLK_DIV / 2 - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(CS_HOLD - 1);
    localparam logic               c_sck_idle = (CPOL != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [c_bits_w-1:0]  r_bits, w_bits_nxt;
    logic [c_w-1:0]       r_shift, w_shift_nxt;
    logic [c_gap_w-1:0]   r_gap, w_gap_nxt;
    logic                 r_last, w_last_nxt;
    logic                 r_cs, w_cs_nxt;
    logic                 r_dc, w_dc_nxt;
    logic                 r_sda, w_sda_nxt;
    logic                 r_sck, w_sck_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_done, w_done_nxt;

    logic                 w_accept;
    logic [c_w-1:0]       w_lane, w_acc, w_packed;
    logic [c_bits_w-1:0]  w_nbits;

    // Kept lanes are compacted towards the MSB end so shifting never skips.
    always_comb begin
        w_lane  = '0;
        w_acc   = '0;
        w_nbits = '0;
        for (int i = BYTES_PER_BEAT - 1; i >= 0; i--) begin
            if (S_AXIS_TKEEP[i]) begin
                w_lane      = '0;
                w_lane[7:0] = S_AXIS_TDATA[8*i +: 8];
                w_acc       = (w_acc << 8) | w_lane;
                w_nbits     = w_nbits + c_bits_w'(8);
            end
        end
        w_packed = w_acc << (c_bits_w'(c_w) - w_nbits);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;
        w_gap_nxt   = r_gap;
        w_last_nxt  = r_last;
        w_cs_nxt    = r_cs;
        w_dc_nxt    = r_dc;
        w_sda_nxt   = r_sda;
        w_done_nxt  = 1'b0;
        w_accept    = S_AXIS_TVALID && r_ready;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = w_packed;
                    w_last_nxt  = S_AXIS_TLAST;
                    w_dc_nxt    = S_AXIS_TUSER;
                    w_cnt_nxt   = '0;
                    w_gap_nxt   = '0;
                    if (w_nbits != '0) begin
                        w_state_nxt = S_SHIFT;
                        w_cs_nxt    = 1'b0;
                        w_bits_nxt  = w_nbits - 1'b1;
                        w_sda_nxt   = w_packed[c_w-1];
                    end else if (S_AXIS_TLAST) begin
                        w_state_nxt = S_GAP;
                        w_cs_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cs_nxt    = 1'b0;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_bits == '0) begin
                        if (r_last) begin
                            w_state_nxt = S_GAP;
                            w_cs_nxt    = 1'b1;
                            w_done_nxt  = 1'b1;
                            w_gap_nxt   = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bits_nxt  = r_bits - 1'b1;
                        w_shift_nxt = r_shift << 1;
                        // Low-idle clock: next bit goes out on the falling edge at the wrap.
                        if (!c_sck_idle) w_sda_nxt = r_shift[c_w-2];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    // High-idle clock: data changes on the mid-period falling edge.
                    if (c_sck_idle && r_cnt == c_cnt_pre) w_sda_nxt = r_shift[c_w-1];
                end
            end
            S_GAP: begin
                if (r_gap == c_gap_last) w_state_nxt = S_IDLE;
                else                     w_gap_nxt   = r_gap + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_sck_nxt   = (w_state_nxt == S_SHIFT && w_cnt_nxt >= c_cnt_half) ? ~c_sck_idle : c_sck_idle;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_gap   <= '0;
            r_last  <= 1'b0;
            r_cs    <= 1'b1;
            r_dc    <= 1'b0;
            r_sda   <= 1'b0;
            r_sck   <= c_sck_idle;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bits  <= w_bits_nxt;
            r_shift <= w_shift_nxt;
            r_gap   <= w_gap_nxt;
            r_last  <= w_last_nxt;
            r_cs    <= w_cs_nxt;
            r_dc    <= w_dc_nxt;
            r_sda   <= w_sda_nxt;
            r_sck   <= w_sck_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign S_AXIS_TREADY = r_ready;
    assign LCD_CS        = r_cs;
    assign LCD_DC        = r_dc;
    assign LCD_SDA       = r_sda;
    assign LCD_SCK       = r_sck;
    assign FRAME_DONE    = r_done;
    assign BUSY          = (r_state != S_IDLE) || !r_cs;

endmodule

`default_nettype wire

// File: tb/tb_st7789_spi_tx.sv
// ============================================================================
// Module   : tb_st7789_spi_tx
// Brief    : Self-checking bench for st7789_spi_tx across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_st7789_spi_tx;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        user;
        logic        last;
        int          nb;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tdata;
    logic [1:0]  tkeep;
    logic        tuser, tlast, tvalid;
    logic [1:0]  sel;
    logic [2:0]  tready, cs, dc, sda, sck, busy, done;
    logic        m_tready, m_cs, m_dc, m_sda, m_sck, m_busy, m_done;

    int   n_vec = 0;
    int   n_fail = 0;
    int   cur_div, cur_hold;
    logic cur_cpol;
    int   n_edges = 0;
    int   exp_edges = 0;
    int   nb = 0;
    int   cyc = 0;
    int   last_edge = 0;
    logic [7:0] shreg;
    logic [8:0] exp_q[$];
    logic prev_sck, prev_sda, prev_dc, prev_cs;
    logic [1:0] prev_sel;

    always #5 clk = ~clk;

    st7789_spi_tx #(.BYTES_PER_BEAT(2), .CLK_DIV(4), .CPOL(1), .CS_HOLD(2)) u_a (
        .CLK(clk), .RESETN(rst_n), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TUSER(tuser), .S_AXIS_TVALID(tvalid && sel == 2'd0), .S_AXIS_TLAST(tlast),
        .S_AXIS_TREADY(tready[0]), .LCD_CS(cs[0]), .LCD_DC(dc[0]), .LCD_SDA(sda[0]),
        .LCD_SCK(sck[0]), .BUSY(busy[0]), .FRAME_DONE(done[0]));

    st7789_spi_tx #(.BYTES_PER_BEAT(1), .CLK_DIV(4), .CPOL(1), .CS_HOLD(2)) u_b (
        .CLK(clk), .RESETN(rst_n), .S_AXIS_TDATA(tdata[7:0]), .S_AXIS_TKEEP(tkeep[0:0]),
        .S_AXIS_TUSER(tuser), .S_AXIS_TVALID(tvalid && sel == 2'd1), .S_AXIS_TLAST(tlast),
        .S_AXIS_TREADY(tready[1]), .LCD_CS(cs[1]), .LCD_DC(dc[1]), .LCD_SDA(sda[1]),
        .LCD_SCK(sck[1]), .BUSY(busy[1]), .FRAME_DONE(done[1]));

    st7789_spi_tx #(.BYTES_PER_BEAT(1), .CLK_DIV(2), .CPOL(0), .CS_HOLD(1)) u_c (
        .CLK(clk), .RESETN(rst_n), .S_AXIS_TDATA(tdata[7:0]), .S_AXIS_TKEEP(tkeep[0:0]),
        .S_AXIS_TUSER(tuser), .S_AXIS_TVALID(tvalid && sel == 2'd2), .S_AXIS_TLAST(tlast),
        .S_AXIS_TREADY(tready[2]), .LCD_CS(cs[2]), .LCD_DC(dc[2]), .LCD_SDA(sda[2]),
        .LCD_SCK(sck[2]), .BUSY(busy[2]), .FRAME_DONE(done[2]));

    assign m_tready = tready[sel];
    assign m_cs     = cs[sel];
    assign m_dc     = dc[sel];
    assign m_sda    = sda[sel];
    assign m_sck    = sck[sel];
    assign m_busy   = busy[sel];
    assign m_done   = done[sel];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Serial receiver: captures SDA on each SCK rising edge and pops the scoreboard per byte.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            nb      = 0;
            n_edges = 0;
        end else if (sel == prev_sel) begin
            if (m_dc !== prev_dc && m_sck !== cur_cpol) begin
                n_fail++;
                $display("FAIL dc_toggle: dc %0b changed while sck active at cycle %0d", m_dc, cyc);
            end
            if (m_sck === 1'b1 && prev_sck === 1'b0) begin
                n_edges++;
                chk("sda_stable_at_edge", m_sda, prev_sda);
                chk("cs_low_before_edge", prev_cs, 1'b0);
                if (nb != 0) chk("edge_spacing", cyc - last_edge, cur_div);
                last_edge = cyc;
                shreg = {shreg[6:0], m_sda};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL byte: got %0h with no byte expected", shreg);
                    end else begin
                        chk("byte_dc_data", {m_dc, shreg}, exp_q.pop_front());
                    end
                end
            end
        end
        prev_sck = m_sck;
        prev_sda = m_sda;
        prev_dc  = m_dc;
        prev_cs  = m_cs;
        prev_sel = sel;
    end

    task automatic select(input logic [1:0] k);
        sel = k;
        case (k)
            2'd0:    begin cur_div = 4; cur_cpol = 1'b1; cur_hold = 2; end
            2'd1:    begin cur_div = 4; cur_cpol = 1'b1; cur_hold = 2; end
            default: begin cur_div = 2; cur_cpol = 1'b0; cur_hold = 1; end
        endcase
        @(negedge clk);
    endtask

    // Drives one beat, queues its expected bytes, and returns just after the accepting edge.
    task automatic accept_beat(input logic [15:0] d, input logic [1:0] k, input logic u,
                               input logic l, input int nbytes, input logic [15:0] e,
                               output bit ok);
        int w;
        tdata  = d;
        tkeep  = k;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        for (int i = 0; i < nbytes; i++) exp_q.push_back({u, e[8*(nbytes-1-i) +: 8]});
        exp_edges += 8 * nbytes;
        w = 0;
        while (!m_tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = m_tready;
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: tready %0b after %0d cycles, expected 1", m_tready, w);
            tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 tvalid = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic u,
                        input logic l, input int nbytes, input logic [15:0] e);
        int t, cs_low, dn, dn_t, shift_len;
        logic dc1;
        bit ok;
        accept_beat(d, k, u, l, nbytes, e, ok);
        if (!ok) return;
        shift_len = 8 * nbytes * cur_div;
        t = 0; cs_low = 0; dn = 0; dn_t = 0; dc1 = 1'bx;
        do begin
            @(negedge clk);
            t++;
            if (t == 1) dc1 = m_dc;
            if (m_done) begin dn++; dn_t = t; end
            if (!m_cs && t <= shift_len) cs_low++;
        end while (!m_tready && t < 3000);
        chk("tready_return_cycle", t, shift_len + 1 + (l ? cur_hold : 0));
        chk("dc_after_accept", dc1, u);
        chk("cs_low_cycles", cs_low, shift_len);
        chk("frame_done_count", dn, l ? 1 : 0);
        if (l) chk("frame_done_cycle", dn_t, shift_len + 1);
        chk("cs_at_ready", m_cs, l);
        chk("busy_at_ready", m_busy, !l);
    endtask

    task automatic drained();
        repeat (4) @(negedge clk);
        chk("scoreboard_left", exp_q.size() + nb, 0);
        chk("rising_edge_count", n_edges, exp_edges);
        n_edges   = 0;
        exp_edges = 0;
    endtask

    vec_t vecs[7];

    initial begin
        int dn;
        bit ok;
        vecs[0] = '{16'hF800, 2'b11, 1'b1, 1'b1, 2, 16'hF800};
        vecs[1] = '{16'h12AB, 2'b01, 1'b1, 1'b0, 1, 16'h00AB};
        vecs[2] = '{16'h0000, 2'b00, 1'b1, 1'b1, 0, 16'h0000};
        vecs[3] = '{16'h2C77, 2'b10, 1'b0, 1'b0, 1, 16'h002C};
        vecs[4] = '{16'h1234, 2'b11, 1'b1, 1'b0, 2, 16'h1234};
        vecs[5] = '{16'h5678, 2'b10, 1'b1, 1'b1, 1, 16'h0056};
        vecs[6] = '{16'hA5C3, 2'b11, 1'b0, 1'b1, 2, 16'hA5C3};

        rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = '0; tuser = 1'b0; tlast = 1'b0;
        sel = 2'd0; prev_sel = 2'd0; cur_div = 4; cur_cpol = 1'b1; cur_hold = 2;
        repeat (3) @(negedge clk);
        chk("rst_cs", m_cs, 1'b1);
        chk("rst_sck", m_sck, 1'b1);
        chk("rst_sda", m_sda, 1'b0);
        chk("rst_dc", m_dc, 1'b0);
        chk("rst_tready", m_tready, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_sck_cpol0", sck[2], 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_after_reset", m_tready, 1'b1);

        select(2'd0);
        for (int i = 0; i < 7; i++)
            send(vecs[i].data, vecs[i].keep, vecs[i].user, vecs[i].last, vecs[i].nb, vecs[i].exp);
        drained();

        select(2'd1);
        send(16'h002A, 2'b01, 1'b0, 1'b1, 1, 16'h002A);
        send(16'h002C, 2'b01, 1'b0, 1'b0, 1, 16'h002C);
        send(16'h00E7, 2'b01, 1'b1, 1'b0, 1, 16'h00E7);
        send(16'h0018, 2'b01, 1'b1, 1'b1, 1, 16'h0018);
        drained();

        select(2'd2);
        send(16'h00A5, 2'b01, 1'b1, 1'b1, 1, 16'h00A5);
        send(16'h003C, 2'b01, 1'b0, 1'b1, 1, 16'h003C);
        drained();

        // Abort mid-frame at bit 5 of the second byte, then restart cleanly.
        select(2'd0);
        accept_beat(16'hBEEF, 2'b11, 1'b1, 1'b1, 2, 16'hBEEF, ok);
        dn = 0;
        repeat (41) begin
            @(negedge clk);
            if (m_done) dn++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        if (m_done) dn++;
        chk("abort_cs", m_cs, 1'b1);
        chk("abort_sck", m_sck, 1'b1);
        chk("abort_sda", m_sda, 1'b0);
        chk("abort_tready", m_tready, 1'b0);
        repeat (2) begin
            @(negedge clk);
            if (m_done) dn++;
        end
        rst_n = 1'b1;
        exp_edges = 0;
        @(negedge clk);
        if (m_done) dn++;
        chk("abort_no_frame_done", dn, 0);
        chk("abort_tready_back", m_tready, 1'b1);
        send(16'h8001, 2'b11, 1'b1, 1'b1, 2, 16'h8001);
        drained();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
